// File: rtl/bt_tx_arbiter.sv
// Purpose: round-robin packet arbiter that frames SYNC/HDR/payload/CSUM onto one shared UART transmitter.
// Latency: grant one cycle after a request is seen in IDLE; each byte launches one cycle after entering its SEND state.
// Backpressure: one byte in flight, next launch only after tx_done_in; requester ready only in FETCH; stalled packets abort with a corrupt checksum.
module bt_tx_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          STALL_TIMEOUT = 100000
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [8*NUM_REQ-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]     req_last_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic [7:0]             tx_data_out,
    output logic                   tx_start_out,
    input  logic                   tx_done_in,
    output logic                   busy_out,
    output logic                   abort_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        SEND_SYNC,
        WAIT_SYNC,
        SEND_HDR,
        WAIT_HDR,
        FETCH,
        SEND_PAY,
        WAIT_PAY,
        SEND_CSUM,
        WAIT_CSUM
    } state_t;

    state_t             state;
    logic [PW-1:0]      rr_ptr;
    logic [3:0]         winner;
    logic [7:0]         checksum;
    logic [7:0]         pay_byte;
    logic               pay_last;
    logic               bad_csum;
    logic [CW-1:0]      stall_cnt;

    logic [NUM_REQ-1:0] valid_rot;
    logic [3:0]         pick;
    logic [PW-1:0]      next_ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               any_valid;

    logic [7:0]         cur_data;
    logic               cur_valid;
    logic               cur_last;

    // Round-robin pick: rotate valids so bit 0 is rr_ptr, lowest set offset wins
    always_comb begin
        int w;
        w           = 0;
        pick        = '0;
        next_ptr    = '0;
        pick_onehot = '0;
        any_valid   = |req_valid_in;
        valid_rot   = NUM_REQ'({req_valid_in, req_valid_in} >> rr_ptr);
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                w           = (int'(rr_ptr) + k) % NUM_REQ;
                pick        = 4'(w);
                next_ptr    = PW'((w + 1) % NUM_REQ);
                pick_onehot = NUM_REQ'(1) << w;
            end
        end
    end

    // Byte path from the granted requester, selected by the one-hot grant
    always_comb begin
        cur_data  = '0;
        cur_valid = |(req_valid_in & grant_out);
        cur_last  = |(req_last_in & grant_out);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_out[i]) begin
                cur_data = req_data_in[8*i +: 8];
            end
        end
    end

    // Frame sequencer: one byte in flight, all outputs registered
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            winner        <= '0;
            checksum      <= '0;
            pay_byte      <= '0;
            pay_last      <= 1'b0;
            bad_csum      <= 1'b0;
            stall_cnt     <= '0;
            req_ready_out <= '0;
            grant_out     <= '0;
            tx_data_out   <= '0;
            tx_start_out  <= 1'b0;
            busy_out      <= 1'b0;
            abort_out     <= 1'b0;
        end else begin
            tx_start_out <= 1'b0;
            abort_out    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_out <= pick_onehot;
                        winner    <= pick;
                        rr_ptr    <= next_ptr;
                        busy_out  <= 1'b1;
                        bad_csum  <= 1'b0;
                        state     <= SEND_SYNC;
                    end
                end
                SEND_SYNC: begin
                    tx_data_out  <= SYNC_BYTE;
                    tx_start_out <= 1'b1;
                    state        <= WAIT_SYNC;
                end
                WAIT_SYNC: begin
                    if (tx_done_in) begin
                        state <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    tx_data_out  <= {4'h0, winner};
                    checksum     <= {4'h0, winner};
                    tx_start_out <= 1'b1;
                    state        <= WAIT_HDR;
                end
                WAIT_HDR: begin
                    if (tx_done_in) begin
                        req_ready_out <= grant_out;
                        stall_cnt     <= '0;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    if (cur_valid) begin
                        pay_byte      <= cur_data;
                        pay_last      <= cur_last;
                        checksum      <= checksum ^ cur_data;
                        req_ready_out <= '0;
                        stall_cnt     <= '0;
                        state         <= SEND_PAY;
                    end else if (stall_cnt == CW'(STALL_TIMEOUT - 1)) begin
                        abort_out     <= 1'b1;
                        bad_csum      <= 1'b1;
                        req_ready_out <= '0;
                        state         <= SEND_CSUM;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                SEND_PAY: begin
                    tx_data_out  <= pay_byte;
                    tx_start_out <= 1'b1;
                    state        <= WAIT_PAY;
                end
                WAIT_PAY: begin
                    if (tx_done_in) begin
                        if (pay_last) begin
                            state <= SEND_CSUM;
                        end else begin
                            req_ready_out <= grant_out;
                            state         <= FETCH;
                        end
                    end
                end
                SEND_CSUM: begin
                    // An inverted checksum tells the receiver the packet was cut short
                    tx_data_out  <= bad_csum ? ~checksum : checksum;
                    tx_start_out <= 1'b1;
                    state        <= WAIT_CSUM;
                end
                WAIT_CSUM: begin
                    if (tx_done_in) begin
                        grant_out <= '0;
                        busy_out  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
